// File: rtl/div_const_pkg.sv
// Shared constants and types for the digit-serial divide-by-constant unit.
package div_const_pkg;
  localparam int W_DEF       = 16;
  localparam int DIVISOR_DEF = 11;
  localparam int REM_W       = 4;
  localparam int STEP_BITS   = 2;
  localparam int NSTEPS      = W_DEF / STEP_BITS;
  localparam int CNT_W       = $clog2(NSTEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_const_step.sv
// One quotient-digit stage: folds STEP_BITS new dividend bits into the running
// remainder and divides by the constant. The caller keeps r_in < DIVISOR, so
// t < 4*DIVISOR and the digit always fits STEP_BITS bits.
module div_const_step #(
  parameter int DIVISOR   = div_const_pkg::DIVISOR_DEF,
  parameter int STEP_BITS = div_const_pkg::STEP_BITS
) (
  input  logic [div_const_pkg::REM_W-1:0] r_in,
  input  logic [STEP_BITS-1:0]            d_in,
  output logic [STEP_BITS-1:0]            q_dig,
  output logic [div_const_pkg::REM_W-1:0] r_out
);
  import div_const_pkg::*;

  localparam int TW = REM_W + STEP_BITS;

  logic [TW-1:0] t;

  // Constant-divisor step; synthesises to a small lookup table.
  always_comb begin
    t     = {r_in, d_in};
    q_dig = STEP_BITS'(t / TW'(DIVISOR));
    r_out = REM_W'(t % TW'(DIVISOR));
  end
endmodule

// File: rtl/div_const_seq.sv
// Digit-serial divide-by-constant: W-bit unsigned dividend / DIVISOR, retiring
// STEP_BITS bits per cycle MSB first. Accept edge E0, steps on E1..E8, result
// held in DONE until taken.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; in_ready is high only in IDLE, out_valid only in DONE, and out_valid
// never drops until out_ready takes the result.
// Optional build macro: DIV_CONST_SELFCHECK_EN adds a dividend shadow register
// and the registered chk_err output.
module div_const_seq #(
  parameter int W         = div_const_pkg::W_DEF,
  parameter int DIVISOR   = div_const_pkg::DIVISOR_DEF,
  parameter int STEP_BITS = div_const_pkg::STEP_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [W-1:0]                    in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [W-1:0]                    out_quot,
  output logic [div_const_pkg::REM_W-1:0] out_rem
`ifdef DIV_CONST_SELFCHECK_EN
  ,
  output logic                            chk_err
`endif
);
  import div_const_pkg::*;

  localparam int STEPS = W / STEP_BITS;
  localparam int CNTW  = $clog2(STEPS + 1);
  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(STEPS - 1);

  div_state_t           state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [W-1:0]         dvd_q, dvd_d;
  logic [W-1:0]         quot_q, quot_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [STEP_BITS-1:0] q_dig;
  logic [REM_W-1:0]     r_next;

  div_const_step #(
    .DIVISOR   (DIVISOR),
    .STEP_BITS (STEP_BITS)
  ) u_step (
    .r_in  (rem_q),
    .d_in  (dvd_q[W-1 -: STEP_BITS]),
    .q_dig (q_dig),
    .r_out (r_next)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
          dvd_d   = in_data;
          quot_d  = '0;
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        dvd_d  = dvd_q << STEP_BITS;
        quot_d = {quot_q[W-STEP_BITS-1:0], q_dig};
        rem_d  = r_next;
        if (cnt_q == LAST_STEP) begin
          // Counter wraps here so it never exceeds STEPS-1.
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign out_quot = quot_q;
  assign out_rem  = rem_q;

`ifdef DIV_CONST_SELFCHECK_EN
  localparam int PW = W + REM_W;

  logic [W-1:0]  shadow_q, shadow_d;
  logic          chk_q, chk_d;
  logic [PW-1:0] recon;

  // Check is computed from the final-step values so it is ready with out_valid.
  always_comb begin
    shadow_d = shadow_q;
    chk_d    = chk_q;
    recon    = PW'(quot_d) * PW'(DIVISOR) + PW'(rem_d);
    if (state_q == IDLE) begin
      chk_d = 1'b0;
      if (in_valid) shadow_d = in_data;
    end else if (state_q == RUN && state_d == DONE) begin
      chk_d = (recon != PW'(shadow_q)) || (rem_d >= REM_W'(DIVISOR));
    end
  end

  // Shadow dividend and registered check flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      chk_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      chk_q    <= chk_d;
    end
  end

  assign chk_err = chk_q;
`endif
endmodule

// File: tb/tb_div_const_seq.sv
// Bench for div_const_seq: directed edge cases, backpressure, mid-run reset and
// randomized handshaking against an arithmetic reference model.
module tb_div_const_seq;
  localparam int W   = 16;
  localparam int DIV = 11;
  localparam int NRAND = 1500;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_quot;
  logic [3:0]   out_rem;
`ifdef DIV_CONST_SELFCHECK_EN
  logic         chk_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_rem_q[$];

  div_const_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quot  (out_quot),
    .out_rem   (out_rem)
`ifdef DIV_CONST_SELFCHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer arithmetic.
  function automatic logic [W-1:0] ref_quot(input logic [W-1:0] v);
    return W'(int'(v) / DIV);
  endfunction
  function automatic logic [3:0] ref_rem(input logic [W-1:0] v);
    return 4'(int'(v) % DIV);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: offer v, wait for acceptance, then count cycles until out_valid.
  task automatic run_div(input logic [W-1:0] v, output int lat, output int acc_cyc);
    int n;
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++;
    if (out_quot !== '0) begin errors++; $display("FAIL reset_quot got %0d exp 0", out_quot); end
    checks++;
    if (out_rem !== 4'd0) begin errors++; $display("FAIL reset_rem got %0d exp 0", out_rem); end
    checks++;
`ifdef DIV_CONST_SELFCHECK_EN
    if (chk_err !== 1'b0) begin errors++; $display("FAIL reset_chk got %0b exp 0", chk_err); end
    checks++;
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_max();
    int lat, acc;
    out_ready = 1'b0;
    run_div(16'hFFFF, lat, acc);
    if (lat !== 8) begin errors++; $display("FAIL max_latency got %0d exp 8", lat); end
    checks++;
    if (out_quot !== 16'd5957) begin errors++; $display("FAIL max_quot got %0d exp 5957", out_quot); end
    checks++;
    if (out_rem !== 4'd8) begin errors++; $display("FAIL max_rem got %0d exp 8", out_rem); end
    checks++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL max_release got valid=%0b ready=%0b exp valid=0 ready=1", out_valid, in_ready);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vals[4];
    int lat, acc, prev_acc;
    vals[0] = 16'd0; vals[1] = 16'd10; vals[2] = 16'd11; vals[3] = 16'd1234;
    prev_acc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_div(vals[i], lat, acc);
      if (out_valid !== 1'b1 || lat !== 8) begin
        errors++; $display("FAIL b2b_latency got %0d exp 8 (value %0d)", lat, vals[i]);
      end
      checks++;
      if (out_quot !== ref_quot(vals[i]) || out_rem !== ref_rem(vals[i])) begin
        errors++; $display("FAIL b2b_result got %0dr%0d exp %0dr%0d", out_quot, out_rem, ref_quot(vals[i]), ref_rem(vals[i]));
      end
      checks++;
      if (i > 0) begin
        if (acc - prev_acc !== 10) begin
          errors++; $display("FAIL b2b_interval got %0d exp 10", acc - prev_acc);
        end
        checks++;
      end
      prev_acc = acc;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat, acc;
    out_ready = 1'b0;
    run_div(16'd1234, lat, acc);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_valid = 1'b1; in_data = 16'd777; end
      tick();
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_flags got valid=%0b ready=%0b exp valid=1 ready=0", out_valid, in_ready);
      end
      checks++;
      if (out_quot !== 16'd112 || out_rem !== 4'd2) begin
        errors++; $display("FAIL bp_hold got %0dr%0d exp 112r2", out_quot, out_rem);
      end
      checks++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (12) tick();
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ignored_pulse got valid=%0b ready=%0b exp valid=0 ready=1", out_valid, in_ready);
    end
    checks++;
  endtask

  task automatic test_reset_mid_run();
    int lat, acc;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got ready=%0b valid=%0b exp ready=1 valid=0", in_ready, out_valid);
    end
    checks++;
    if (out_quot !== '0 || out_rem !== 4'd0) begin
      errors++; $display("FAIL midrst_data got %0dr%0d exp 0r0", out_quot, out_rem);
    end
    checks++;
`ifdef DIV_CONST_SELFCHECK_EN
    if (chk_err !== 1'b0) begin errors++; $display("FAIL midrst_chk got %0b exp 0", chk_err); end
    checks++;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    run_div(16'd22, lat, acc);
    if (lat !== 8 || out_quot !== 16'd2 || out_rem !== 4'd0) begin
      errors++; $display("FAIL midrst_next got %0dr%0d lat %0d exp 2r0 lat 8", out_quot, out_rem, lat);
    end
    checks++;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_sweep();
    logic [W-1:0] v;
    int lat, acc;
    out_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (i < 150)      v = W'(i);
      else if (i < 300) v = W'(65535 - (i - 150));
      else              v = W'($urandom);
      run_div(v, lat, acc);
      if (out_valid !== 1'b1 || out_quot !== ref_quot(v) || out_rem !== ref_rem(v)) begin
        errors++; $display("FAIL sweep_result in %0d got %0dr%0d exp %0dr%0d", v, out_quot, out_rem, ref_quot(v), ref_rem(v));
      end
      checks++;
      if (out_rem >= 4'(DIV)) begin
        errors++; $display("FAIL sweep_rem_range got %0d exp below %0d", out_rem, DIV);
      end
      checks++;
`ifdef DIV_CONST_SELFCHECK_EN
      if (chk_err !== 1'b0) begin errors++; $display("FAIL sweep_chk in %0d got %0b exp 0", v, chk_err); end
      checks++;
`endif
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int done_cnt = 0;
    int acc_cnt = 0;
    int budget = 0;
    logic stalled = 1'b0;
    logic [W-1:0] sq = '0;
    logic [3:0]   sr = '0;
    logic [W-1:0] eq;
    logic [3:0]   er;
    exp_q.delete();
    exp_rem_q.delete();
    while (done_cnt < NRAND && budget < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0) && (acc_cnt < NRAND);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (stalled) begin
        if (out_valid !== 1'b1 || out_quot !== sq || out_rem !== sr) begin
          errors++; $display("FAIL rand_hold got v=%0b %0dr%0d exp v=1 %0dr%0d", out_valid, out_quot, out_rem, sq, sr);
        end
        checks++;
      end
      stalled = out_valid && !out_ready;
      sq = out_quot;
      sr = out_rem;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_quot(in_data));
        exp_rem_q.push_back(ref_rem(in_data));
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra got %0dr%0d exp no result", out_quot, out_rem);
        end else begin
          eq = exp_q.pop_front();
          er = exp_rem_q.pop_front();
          if (out_quot !== eq || out_rem !== er) begin
            errors++; $display("FAIL rand_result got %0dr%0d exp %0dr%0d", out_quot, out_rem, eq, er);
          end
        end
        checks++;
        done_cnt++;
      end
      tick();
      budget++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (done_cnt !== NRAND || exp_q.size() !== 0) begin
      errors++; $display("FAIL rand_count got %0d done %0d pending exp %0d done 0 pending", done_cnt, exp_q.size(), NRAND);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
